// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES widths, GF(2^8) constants, helper functions and FSM encoding
// Used by the MixColumns and InvMixColumns datapaths.
// xtime multiplies by x modulo 0x11B.
// gf_mul_const multiplies by one of the small constants used in either matrix.
package aes_pkg;

  localparam int TEXT_WIDTH  = 128;
  localparam int BYTE_WIDTH  = 8;
  localparam int MATRIX_SIZE = 4;
  localparam int COL_WIDTH   = MATRIX_SIZE * BYTE_WIDTH;

  localparam logic [BYTE_WIDTH-1:0] GF_POLY = 8'h1B;
  localparam logic [BYTE_WIDTH-1:0] C_01    = 8'h01;
  localparam logic [BYTE_WIDTH-1:0] C_02    = 8'h02;
  localparam logic [BYTE_WIDTH-1:0] C_03    = 8'h03;
  localparam logic [BYTE_WIDTH-1:0] C_09    = 8'h09;
  localparam logic [BYTE_WIDTH-1:0] C_0B    = 8'h0B;
  localparam logic [BYTE_WIDTH-1:0] C_0D    = 8'h0D;
  localparam logic [BYTE_WIDTH-1:0] C_0E    = 8'h0E;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } aes_fsm_e;

  function automatic logic [BYTE_WIDTH-1:0] xtime(input logic [BYTE_WIDTH-1:0] a);
    return {a[BYTE_WIDTH-2:0], 1'b0} ^ (a[BYTE_WIDTH-1] ? GF_POLY : 8'h00);
  endfunction

  // Products come from one shared x2/x4/x8 chain.
  // Only the constants of the forward and inverse matrices are meaningful.
  function automatic logic [BYTE_WIDTH-1:0] gf_mul_const(input logic [BYTE_WIDTH-1:0] a,
                                                         input logic [BYTE_WIDTH-1:0] c);
    logic [BYTE_WIDTH-1:0] x2;
    logic [BYTE_WIDTH-1:0] x4;
    logic [BYTE_WIDTH-1:0] x8;
    logic [BYTE_WIDTH-1:0] r;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      C_01:    r = a;
      C_02:    r = x2;
      C_03:    r = x2 ^ a;
      C_09:    r = x8 ^ a;
      C_0B:    r = x8 ^ x2 ^ a;
      C_0D:    r = x8 ^ x4 ^ a;
      C_0E:    r = x8 ^ x4 ^ x2;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// rtl/inv_mix_single_column.sv - combinational InvMixColumns on one 32-bit column
// Ports:
//   col_i : input column, row 0 in [31:24].
//   col_o : transformed column, same layout.
module inv_mix_single_column
  import aes_pkg::*;
(
  input  logic [COL_WIDTH-1:0] col_i,
  output logic [COL_WIDTH-1:0] col_o
);

  logic [BYTE_WIDTH-1:0] a0, a1, a2, a3;
  logic [BYTE_WIDTH-1:0] b0, b1, b2, b3;

  assign {a0, a1, a2, a3} = col_i;

  always_comb begin
    b0 = gf_mul_const(a0, C_0E) ^ gf_mul_const(a1, C_0B) ^ gf_mul_const(a2, C_0D) ^ gf_mul_const(a3, C_09);
    b1 = gf_mul_const(a0, C_09) ^ gf_mul_const(a1, C_0E) ^ gf_mul_const(a2, C_0B) ^ gf_mul_const(a3, C_0D);
    b2 = gf_mul_const(a0, C_0D) ^ gf_mul_const(a1, C_09) ^ gf_mul_const(a2, C_0E) ^ gf_mul_const(a3, C_0B);
    b3 = gf_mul_const(a0, C_0B) ^ gf_mul_const(a1, C_0D) ^ gf_mul_const(a2, C_09) ^ gf_mul_const(a3, C_0E);
  end

  assign col_o = {b0, b1, b2, b3};

endmodule

// File: rtl/inv_mixcolumns_iter.sv
// rtl/inv_mixcolumns_iter.sv - iterative AES InvMixColumns, COLS_PER_CYCLE columns per clock
// Ports:
//   clk_i, rst_i       : clock and asynchronous active-high reset.
//   state_i/valid_i/ready_o : input state handshake (column 0 in [127:96]).
//   state_o/valid_o/ready_i : result handshake; the result is held until ready_i.
// Legal values of COLS_PER_CYCLE are 1, 2 and 4.
module inv_mixcolumns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [TEXT_WIDTH-1:0] state_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [TEXT_WIDTH-1:0] state_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  // Packed column view of the working register.
  // Column c sits at index 3-c, so the flat bits match the state_i layout.
  typedef logic [MATRIX_SIZE-1:0][COL_WIDTH-1:0] state_cols_t;

  // Value of the counter when the final group of columns is processed.
  localparam logic [1:0] LAST_CNT = 2'(MATRIX_SIZE - COLS_PER_CYCLE);

  aes_fsm_e    fsm_q, fsm_d;
  logic [1:0]  cnt_q, cnt_d;
  state_cols_t work_q, work_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;

  logic [1:0]           col_idx [COLS_PER_CYCLE];
  logic [COL_WIDTH-1:0] col_in  [COLS_PER_CYCLE];
  logic [COL_WIDTH-1:0] col_out [COLS_PER_CYCLE];

  always_comb begin
    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
      col_idx[i] = cnt_q + 2'(i);
      col_in[i]  = work_q[2'd3 - col_idx[i]];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    inv_mix_single_column u_col (
      .col_i (col_in[g]),
      .col_o (col_out[g])
    );
  end

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    ready_d = ready_q;
    valid_d = valid_q;
    case (fsm_q)
      ST_IDLE: begin
        if (valid_i && ready_q) begin
          work_d  = state_i;
          cnt_d   = '0;
          ready_d = 1'b0;
          fsm_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
          work_d[2'd3 - col_idx[i]] = col_out[i];
        end
        // The counter wraps back to 0 on the last group.
        // The FSM leaves BUSY at the same time.
        cnt_d = cnt_q + 2'(COLS_PER_CYCLE);
        if (cnt_q == LAST_CNT) begin
          valid_d = 1'b1;
          fsm_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ready_i) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          fsm_d   = ST_IDLE;
        end
      end
      default: begin
        fsm_d   = ST_IDLE;
        cnt_d   = '0;
        ready_d = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q   <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign state_o = work_q;

endmodule
